// File: rtl/pc_sequencer.sv
// pc_sequencer: falling-edge program counter with circular return-address stack.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    ptr, ptr_d, top;
    logic [PW:0]      count, count_d;
    logic [WIDTH-1:0] pc_d;
    logic             ovf_d, unf_d, push, bad;

    assign pc_next_seq = pc + INC_W;
    assign ras_empty   = count == '0;
    assign ras_full    = count == (PW+1)'(RAS_DEPTH);
    assign top         = ptr - 1'b1;

`ifdef PC_ALIGN_CHECK_EN
    assign bad = (target & (INC_W - 1'b1)) != '0;
    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) misalign <= 1'b0;
        else misalign <= !stall && !ret && (call || branch) && bad;
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_next_seq;
        ptr_d   = ptr;
        count_d = count;
        push    = 1'b0;
        ovf_d   = ras_ovf;
        unf_d   = ras_unf;
        if (stall) begin
            pc_d = pc;
        end else if (ret) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_d    = stack[top];
                ptr_d   = top;
                count_d = count - 1'b1;
            end
        end else if ((call || branch) && !bad) begin
            pc_d = target;
            if (call) begin
                // a push while full lands on the oldest slot, so count stays saturated
                push    = 1'b1;
                ptr_d   = ptr + 1'b1;
                count_d = ras_full ? count : count + 1'b1;
                ovf_d   = ras_ovf | ras_full;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) begin
            pc      <= RESET_VEC;
            ptr     <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            pc      <= pc_d;
            ptr     <= ptr_d;
            count   <= count_d;
            ras_ovf <= ovf_d;
            ras_unf <= unf_d;
        end

    always_ff @(negedge clk)
        if (push && rst_n) stack[ptr] <= pc_next_seq;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] pc, pc_next_seq;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

    int passed = 0, total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_ovf, m_unf, m_mis;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .call(call),
        .ret(ret), .target(target), .pc(pc), .pc_next_seq(pc_next_seq),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".seq"}, pc_next_seq, m_pc + 32'd4);
        check({tag, ".empty"}, 32'(ras_empty), 32'(m_q.size() == 0));
        check({tag, ".full"}, 32'(ras_full), 32'(m_q.size() == 4));
        check({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
        check({tag, ".mis"}, 32'(misalign), 32'(m_mis));
    endtask

    task automatic model(input bit s, input bit b, input bit c, input bit r, input logic [31:0] t);
        logic [31:0] seq;
        seq   = m_pc + 32'd4;
        m_mis = 1'b0;
        if (!s) begin
            if (r) begin
                if (m_q.size() == 0) begin
                    m_unf = 1'b1;
                    m_pc  = seq;
                end else m_pc = m_q.pop_back();
            end else if (c || b) begin
                if (ALIGN && t[1:0] != 2'b00) begin
                    m_pc  = seq;
                    m_mis = 1'b1;
                end else begin
                    if (c) begin
                        if (m_q.size() == 4) begin
                            void'(m_q.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_q.push_back(seq);
                    end
                    m_pc = t;
                end
            end else m_pc = seq;
        end
    endtask

    task automatic step(input string tag, input bit s, input bit b, input bit c, input bit r, input logic [31:0] t);
        stall = s; branch = b; call = c; ret = r; target = t;
        @(negedge clk);
        model(s, b, c, r, t);
        @(posedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_pc = 32'd0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
        check_all({tag, ".async"});
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        check_all({tag, ".held"});
        stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        do_reset("reset");
        for (int i = 1; i <= 3; i++) begin
            step("idle", 0, 0, 0, 0, 0);
            check("idle.const", pc, 32'(4 * i));
        end

        step("br10", 0, 1, 0, 0, 32'h10);
        step("call100", 0, 0, 1, 0, 32'h100);
        check("call100.const", pc, 32'h100);
        step("ret14", 0, 0, 0, 1, 0);
        check("ret14.const", pc, 32'h14);

        step("br1000", 0, 1, 0, 0, 32'h1000);
        for (int i = 2; i <= 6; i++) step("nest.call", 0, 0, 1, 0, 32'(i * 32'h1000));
        check("nest.ovf", 32'(ras_ovf), 32'd1);
        for (int i = 5; i >= 2; i--) begin
            step("nest.ret", 0, 0, 0, 1, 0);
            check("nest.retval", pc, 32'(i * 32'h1000 + 4));
        end
        step("nest.ret5", 0, 0, 0, 1, 0);
        check("nest.ret5.pc", pc, 32'h2008);
        check("nest.unf", 32'(ras_unf), 32'd1);

        @(posedge clk);
        call = 1'b1; target = 32'h200;
        do_reset("midcall");
        step("post.reset", 0, 0, 0, 0, 0);
        check("post.reset.const", pc, 32'h4);

        step("stall.pre", 0, 0, 1, 0, 32'h300);
        for (int i = 0; i < 3; i++) step("stall.call", 1, 0, 1, 0, 32'h400);
        step("stall.go", 0, 0, 1, 0, 32'h400);
        check("stall.go.const", pc, 32'h400);

        step("wrap.br", 0, 1, 0, 0, 32'hFFFF_FFFC);
        step("wrap.seq", 0, 0, 0, 0, 0);
        check("wrap.const", pc, 32'h0);
        step("callret", 0, 0, 1, 1, 32'h500);
        check("callret.pc", pc, 32'h304);

        step("br.pre", 0, 1, 0, 0, 32'h40);
        step("br102", 0, 1, 0, 0, 32'h102);
        check("br102.const", pc, ALIGN ? 32'h44 : 32'h102);
        step("br102.after", 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if (i % 150 == 149) begin
                @(posedge clk);
                do_reset("rand.reset");
            end
            step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, t);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
